axis_req_latency_probe: RTL and testbench
=========================================

// Module: axis_req_latency_probe
// PURPOSE
// Synthesizable in-line probe for the RDM request/reply AXI-Stream path. It forwards the
// request stream to the DUT and applies an optional outstanding-request throttle. It also
// timestamps each request and matches replies in FIFO order, producing sent/received
// counts and min/max/last/sum latency statistics.
// PARAMETERS
// DATA_WIDTH  256  request tdata width; tkeep width is DATA_WIDTH/8
// USER_WIDTH  64   request tuser width
// TS_WIDTH    32   free-running timestamp width; latency is computed mod 2^TS_WIDTH
// CNT_WIDTH   32   width of nr_sent/nr_received/lat_sum
// DEPTH       16   timestamp FIFO entries (power of 2, >=2); max outstanding requests
// PORTS
// clk             in   1             single clock for all logic
// sys_rst         in   1             asynchronous reset, active-high
// clear           in   1             sync; zeroes stats and error flags (FIFO untouched)
// limit_en        in   1             1 = enforce max_outstanding
// max_outstanding in   $clog2(DEPTH)+1  outstanding limit when limit_en=1
// s_req_tdata/tkeep/tuser/tlast/tvalid in, s_req_tready out   upstream request stream
// m_req_tdata/tkeep/tuser/tlast/tvalid out, m_req_tready in   request stream to DUT
// rpl_tvalid/rpl_tready/rpl_tlast  in   1 each  tap on the reply stream (monitor only)
// outstanding     out  $clog2(DEPTH)+1  FIFO occupancy
// nr_sent/nr_received  out  CNT_WIDTH  accepted request starts / matched reply ends
// lat_last/lat_min/lat_max  out  TS_WIDTH  latency stats, in clk cycles
// lat_sum         out  CNT_WIDTH     saturating sum of latencies
// lat_valid       out  1             1-cycle pulse when lat_* is updated
// underflow       out  1             sticky; reply tlast seen with empty FIFO
// BEHAVIOUR
// - Reset: every output register is 0, except lat_min = all-ones. in_pkt=0, FIFO empty, ts=0.
// - ts increments every cycle and wraps.
// - Data path: tdata/tkeep/tuser/tlast are combinational pass-through, zero latency.
// - Gate: pass = in_pkt | (!full & (!limit_en | outstanding < max_outstanding)).
//   m_req_tvalid = s_req_tvalid & pass; s_req_tready = m_req_tready & pass.
//   Throttling therefore happens only at packet boundaries and never splits a packet.
// - in_pkt: set on an accepted beat with tlast=0; cleared on an accepted beat with tlast=1.
// - Request start: the first accepted beat with in_pkt=0. On a start, push ts and
//   increment nr_sent. A single-beat packet is both a start and an end.
// - Reply end: rpl_tvalid & rpl_tready & rpl_tlast.
//   - FIFO non-empty: pop the head; lat = ts - head (mod 2^TS_WIDTH), minimum 1.
//   - Registered 1 cycle after the reply end: lat_last, lat_min/lat_max (compare),
//     lat_sum (saturates at all-ones), nr_received+1, lat_valid=1.
// - Reply end with FIFO empty: set underflow and leave the stats unchanged. This also
//   applies when a push happens in the same cycle, because a same-cycle push is not
//   visible to the pop.
// - Push and pop in the same cycle with FIFO non-empty: occupancy is unchanged; pointers
//   wrap modulo DEPTH.
// - Full: pass=0 outside a packet, so the FIFO cannot overflow.
// - clear: the next cycle shows stats=0, lat_min=all-ones, underflow=0. outstanding and
//   in_pkt are retained. If a pop completes on the same edge as clear, clear wins.
// - Reset mid-packet: all state is dropped. Upstream must restart its packet.
// - max_outstanding=0 with limit_en=1 blocks all new packets.
// TESTING
// 1. Send a 3-beat request with first beat at ts=5 and a reply tlast at ts=15.
//    -> lat_last=min=max=sum=10, nr_sent=nr_received=1, outstanding=0, one lat_valid pulse.
// 2. limit_en=1, max_outstanding=2, three back-to-back 1-beat requests, no replies.
//    -> the third is held (s_req_tready=0, m_req_tvalid=0) and outstanding=2.
//    Then one reply -> the third is accepted the next cycle.
// 3. limit_en=1, max_outstanding=1, one 4-beat request with m_req_tready=1.
//    -> all 4 beats pass on consecutive cycles while outstanding=1 after beat 1.
// 4. Reply tlast with outstanding=0 -> underflow=1 (sticky), nr_received unchanged,
//    no lat_valid pulse.
// 5. TS_WIDTH=8, request start at ts=250, reply end at ts=4 -> lat_last=10.
// 6. DEPTH=4, limit_en=0, 4 requests outstanding -> the fifth is blocked.
//    Then assert clear, then sys_rst mid-packet.
//    -> clear zeroes stats with outstanding=4; reset gives all outputs at reset values,
//       in_pkt=0, and s_req_tready follows m_req_tready.

Source files
------------

// File: rtl/axis_req_latency_probe.sv
// In-line request/reply probe: forwards the request stream with an optional outstanding-request
// throttle, timestamps request starts and matches reply ends in FIFO order for latency stats.
//
// state   | meaning
// ST_IDLE | between request packets; a new packet may be throttled
// ST_PKT  | inside a request packet; beats always pass
module axis_req_latency_probe #(
    parameter int DATA_WIDTH = 256,
    parameter int USER_WIDTH = 64,
    parameter int TS_WIDTH   = 32,
    parameter int CNT_WIDTH  = 32,
    parameter int DEPTH      = 16
) (
    input  logic                      clk,
    input  logic                      sys_rst,
    input  logic                      clear,
    input  logic                      limit_en,
    input  logic [$clog2(DEPTH):0]    max_outstanding,
    input  logic [DATA_WIDTH-1:0]     s_req_tdata,
    input  logic [DATA_WIDTH/8-1:0]   s_req_tkeep,
    input  logic [USER_WIDTH-1:0]     s_req_tuser,
    input  logic                      s_req_tlast,
    input  logic                      s_req_tvalid,
    output logic                      s_req_tready,
    output logic [DATA_WIDTH-1:0]     m_req_tdata,
    output logic [DATA_WIDTH/8-1:0]   m_req_tkeep,
    output logic [USER_WIDTH-1:0]     m_req_tuser,
    output logic                      m_req_tlast,
    output logic                      m_req_tvalid,
    input  logic                      m_req_tready,
    input  logic                      rpl_tvalid,
    input  logic                      rpl_tready,
    input  logic                      rpl_tlast,
    output logic [$clog2(DEPTH):0]    outstanding,
    output logic [CNT_WIDTH-1:0]      nr_sent,
    output logic [CNT_WIDTH-1:0]      nr_received,
    output logic [TS_WIDTH-1:0]       lat_last,
    output logic [TS_WIDTH-1:0]       lat_min,
    output logic [TS_WIDTH-1:0]       lat_max,
    output logic [CNT_WIDTH-1:0]      lat_sum,
    output logic                      lat_valid,
    output logic                      underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = ((TS_WIDTH > CNT_WIDTH) ? TS_WIDTH : CNT_WIDTH) + 1;

    typedef enum logic {ST_IDLE, ST_PKT} state_t;

    state_t                r_state, w_state_nxt;
    logic [TS_WIDTH-1:0]   r_ts;
    logic [TS_WIDTH-1:0]   r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic [CNT_WIDTH-1:0]  r_nr_sent, r_nr_received, r_lat_sum;
    logic [TS_WIDTH-1:0]   r_lat_last, r_lat_min, r_lat_max;
    logic                  r_lat_valid, r_underflow;

    logic                  w_full, w_pass, w_acc, w_push, w_rpl_end, w_pop, w_underflow_ev;
    logic [TS_WIDTH-1:0]   w_lat_raw, w_lat;
    logic [SW-1:0]         w_sum;

    assign w_full         = (r_count == CW'(DEPTH));
    assign w_pass         = (r_state == ST_PKT) |
                            (!w_full & (!limit_en | (r_count < max_outstanding)));
    assign w_acc          = s_req_tvalid & m_req_tready & w_pass;
    assign w_push         = w_acc & (r_state == ST_IDLE);
    assign w_rpl_end      = rpl_tvalid & rpl_tready & rpl_tlast;
    // A same-cycle push is not visible here: the pop only sees the registered occupancy.
    assign w_pop          = w_rpl_end & (r_count != '0);
    assign w_underflow_ev = w_rpl_end & (r_count == '0);

    assign w_lat_raw = r_ts - r_mem[r_rd_ptr];
    assign w_lat     = (w_lat_raw == '0) ? TS_WIDTH'(1) : w_lat_raw;
    assign w_sum     = SW'(r_lat_sum) + SW'(w_lat);

    assign m_req_tdata  = s_req_tdata;
    assign m_req_tkeep  = s_req_tkeep;
    assign m_req_tuser  = s_req_tuser;
    assign m_req_tlast  = s_req_tlast;
    assign m_req_tvalid = s_req_tvalid & w_pass;
    assign s_req_tready = m_req_tready & w_pass;

    always_comb begin
        w_state_nxt = r_state;
        if (w_acc) begin
            w_state_nxt = s_req_tlast ? ST_IDLE : ST_PKT;
        end
    end

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state <= ST_IDLE;
            r_ts    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ts    <= r_ts + TS_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= r_ts;
        end
    end

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push && !w_pop)      r_count <= r_count + CW'(1);
            else if (w_pop && !w_push) r_count <= r_count - CW'(1);
        end
    end

    // clear takes priority over any event completing on the same edge.
    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_nr_sent     <= '0;
            r_nr_received <= '0;
            r_lat_last    <= '0;
            r_lat_min     <= '1;
            r_lat_max     <= '0;
            r_lat_sum     <= '0;
            r_lat_valid   <= 1'b0;
            r_underflow   <= 1'b0;
        end else begin
            r_lat_valid <= 1'b0;
            if (clear) begin
                r_nr_sent     <= '0;
                r_nr_received <= '0;
                r_lat_last    <= '0;
                r_lat_min     <= '1;
                r_lat_max     <= '0;
                r_lat_sum     <= '0;
                r_underflow   <= 1'b0;
            end else begin
                if (w_push)         r_nr_sent   <= r_nr_sent + CNT_WIDTH'(1);
                if (w_underflow_ev) r_underflow <= 1'b1;
                if (w_pop) begin
                    r_lat_last    <= w_lat;
                    r_nr_received <= r_nr_received + CNT_WIDTH'(1);
                    r_lat_valid   <= 1'b1;
                    if (w_lat < r_lat_min) r_lat_min <= w_lat;
                    if (w_lat > r_lat_max) r_lat_max <= w_lat;
                    r_lat_sum <= (w_sum[SW-1:CNT_WIDTH] != '0) ? '1 : w_sum[CNT_WIDTH-1:0];
                end
            end
        end
    end

    assign outstanding = r_count;
    assign nr_sent     = r_nr_sent;
    assign nr_received = r_nr_received;
    assign lat_last    = r_lat_last;
    assign lat_min     = r_lat_min;
    assign lat_max     = r_lat_max;
    assign lat_sum     = r_lat_sum;
    assign lat_valid   = r_lat_valid;
    assign underflow   = r_underflow;

endmodule

// File: tb/tb_axis_req_latency_probe.sv
// Bench for axis_req_latency_probe: directed sequences plus a timestamp scoreboard that
// predicts every lat_valid pulse and the stats it carries.
module tb_axis_req_latency_probe;
    localparam int DW  = 32;
    localparam int UW  = 8;
    localparam int TSW = 8;
    localparam int CNW = 8;
    localparam int DEP = 4;
    localparam int CW  = 3;

    logic            clk = 1'b0;
    logic            sys_rst = 1'b1;
    logic            clear = 1'b0, limit_en = 1'b0;
    logic [CW-1:0]   max_outstanding = '0;
    logic [DW-1:0]   s_req_tdata = '0;
    logic [DW/8-1:0] s_req_tkeep = '0;
    logic [UW-1:0]   s_req_tuser = '0;
    logic            s_req_tlast = 1'b0, s_req_tvalid = 1'b0, s_req_tready;
    logic [DW-1:0]   m_req_tdata;
    logic [DW/8-1:0] m_req_tkeep;
    logic [UW-1:0]   m_req_tuser;
    logic            m_req_tlast, m_req_tvalid;
    logic            m_req_tready = 1'b1;
    logic            rpl_tvalid = 1'b0, rpl_tready = 1'b0, rpl_tlast = 1'b0;
    logic [CW-1:0]   outstanding;
    logic [CNW-1:0]  nr_sent, nr_received, lat_sum;
    logic [TSW-1:0]  lat_last, lat_min, lat_max;
    logic            lat_valid, underflow;

    axis_req_latency_probe #(
        .DATA_WIDTH(DW), .USER_WIDTH(UW), .TS_WIDTH(TSW), .CNT_WIDTH(CNW), .DEPTH(DEP)
    ) dut (
        .clk(clk), .sys_rst(sys_rst), .clear(clear), .limit_en(limit_en),
        .max_outstanding(max_outstanding),
        .s_req_tdata(s_req_tdata), .s_req_tkeep(s_req_tkeep), .s_req_tuser(s_req_tuser),
        .s_req_tlast(s_req_tlast), .s_req_tvalid(s_req_tvalid), .s_req_tready(s_req_tready),
        .m_req_tdata(m_req_tdata), .m_req_tkeep(m_req_tkeep), .m_req_tuser(m_req_tuser),
        .m_req_tlast(m_req_tlast), .m_req_tvalid(m_req_tvalid), .m_req_tready(m_req_tready),
        .rpl_tvalid(rpl_tvalid), .rpl_tready(rpl_tready), .rpl_tlast(rpl_tlast),
        .outstanding(outstanding), .nr_sent(nr_sent), .nr_received(nr_received),
        .lat_last(lat_last), .lat_min(lat_min), .lat_max(lat_max), .lat_sum(lat_sum),
        .lat_valid(lat_valid), .underflow(underflow)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Bench timestamp: equals the probe's clock count since reset release.
    logic [TSW-1:0] tb_ts;
    always @(posedge clk or posedge sys_rst) begin
        if (sys_rst) tb_ts <= '0;
        else         tb_ts <= tb_ts + 8'd1;
    end

    typedef struct {
        logic [TSW-1:0] last, mn, mx;
        logic [CNW-1:0] sum, rcv;
    } stat_t;

    logic [TSW-1:0] ts_q [$];
    stat_t          exp_q [$];
    stat_t          m;
    logic [CNW-1:0] m_sent;
    logic           m_in_pkt, m_underflow, exp_due;
    int             n_lv = 0;

    task automatic model_reset_stats();
        m.last = '0; m.mn = '1; m.mx = '0; m.sum = '0; m.rcv = '0;
        m_sent = '0; m_underflow = 1'b0;
    endtask

    // Outputs are checked against the model, then the upcoming edge's events are predicted.
    always @(negedge clk) begin
        if (sys_rst) begin
            ts_q.delete(); exp_q.delete();
            model_reset_stats();
            m_in_pkt = 1'b0; exp_due = 1'b0;
        end else begin
            stat_t e;
            chk("lat_valid", lat_valid, exp_due);
            if (lat_valid) n_lv++;
            if (lat_valid && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sb_lat_last", lat_last, e.last);
                chk("sb_lat_min", lat_min, e.mn);
                chk("sb_lat_max", lat_max, e.mx);
                chk("sb_lat_sum", lat_sum, e.sum);
                chk("sb_nr_received", nr_received, e.rcv);
            end
            chk("outstanding", outstanding, ts_q.size());
            chk("nr_sent", nr_sent, m_sent);
            chk("underflow", underflow, m_underflow);
            chk("data_pass", {m_req_tdata, m_req_tkeep, m_req_tuser, m_req_tlast},
                {s_req_tdata, s_req_tkeep, s_req_tuser, s_req_tlast});
            exp_due = 1'b0;
            if (rpl_tvalid && rpl_tready && rpl_tlast) begin
                if (ts_q.size() == 0) begin
                    m_underflow = 1'b1;
                end else begin
                    logic [TSW-1:0] h, lat;
                    int s;
                    h = ts_q.pop_front();
                    lat = tb_ts - h;
                    if (lat == 0) lat = 8'd1;
                    if (!clear) begin
                        m.last = lat;
                        if (lat < m.mn) m.mn = lat;
                        if (lat > m.mx) m.mx = lat;
                        s = int'(m.sum) + int'(lat);
                        m.sum = (s > 255) ? 8'hFF : 8'(s);
                        m.rcv = m.rcv + 8'd1;
                        exp_q.push_back(m);
                        exp_due = 1'b1;
                    end
                end
            end
            if (s_req_tvalid && s_req_tready) begin
                if (!m_in_pkt) begin
                    ts_q.push_back(tb_ts);
                    m_sent = m_sent + 8'd1;
                end
                m_in_pkt = !s_req_tlast;
            end
            if (clear) model_reset_stats();
        end
    end

    task automatic beat(input logic last, output int waits);
        s_req_tvalid = 1'b1; s_req_tlast = last;
        s_req_tdata = $urandom; s_req_tkeep = 4'($urandom); s_req_tuser = 8'($urandom);
        waits = 0;
        @(negedge clk);
        while (!s_req_tready && waits < 300) begin
            waits++;
            @(negedge clk);
        end
        chk("req_accept", s_req_tready, 1'b1);
        @(posedge clk); #1;
        s_req_tvalid = 1'b0; s_req_tlast = 1'b0;
    endtask

    task automatic reply();
        rpl_tvalid = 1'b1; rpl_tready = 1'b1; rpl_tlast = 1'b1;
        @(posedge clk); #1;
        rpl_tvalid = 1'b0; rpl_tready = 1'b0; rpl_tlast = 1'b0;
    endtask

    task automatic goto_ts(input logic [TSW-1:0] t);
        for (int k = 0; k < 600; k++) begin
            if (tb_ts == t) break;
            @(posedge clk); #1;
        end
        chk("goto_ts", tb_ts, t);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not complete, checks=%0d", n_chk);
        $fatal(1);
    end

    initial begin
        int w;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outstanding", outstanding, 0);
        chk("rst_lat_min", lat_min, 8'hFF);
        chk("rst_nr_sent", nr_sent, 0);
        chk("rst_underflow", underflow, 0);
        chk("rst_tready", s_req_tready, 1);
        sys_rst = 1'b0;

        // Basic 3-beat request, latency 10; a reply beat without tready must not count.
        goto_ts(8'd5);
        beat(1'b0, w); beat(1'b0, w); beat(1'b1, w);
        chk("t1_nr_sent", nr_sent, 1);
        goto_ts(8'd12);
        rpl_tvalid = 1'b1; rpl_tlast = 1'b1; rpl_tready = 1'b0;
        @(posedge clk); #1;
        rpl_tvalid = 1'b0; rpl_tlast = 1'b0;
        goto_ts(8'd15);
        reply();
        chk("t1_lat_valid", lat_valid, 1);
        chk("t1_lat_last", lat_last, 10);
        chk("t1_lat_min", lat_min, 10);
        chk("t1_lat_max", lat_max, 10);
        chk("t1_lat_sum", lat_sum, 10);
        chk("t1_nr_received", nr_received, 1);
        chk("t1_outstanding", outstanding, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("t1_pulses", n_lv, 1);

        // Outstanding limit of 2 holds the third request until a reply.
        limit_en = 1'b1; max_outstanding = 3'd2;
        beat(1'b1, w); beat(1'b1, w);
        s_req_tvalid = 1'b1; s_req_tlast = 1'b1;
        @(negedge clk);
        chk("t2_tready_held", s_req_tready, 0);
        chk("t2_tvalid_held", m_req_tvalid, 0);
        chk("t2_outstanding", outstanding, 2);
        repeat (3) @(posedge clk);
        #1;
        reply();
        chk("t2_tready_after_reply", s_req_tready, 1);
        @(posedge clk); #1;
        s_req_tvalid = 1'b0; s_req_tlast = 1'b0;
        chk("t2_outstanding_after", outstanding, 2);
        reply(); reply();

        // Limit of 1 never splits a packet.
        max_outstanding = 3'd1;
        beat(1'b0, w);
        chk("t3_outstanding", outstanding, 1);
        for (int i = 1; i < 4; i++) begin
            beat(i == 3, w);
            chk("t3_burst_wait", w, 0);
        end
        s_req_tvalid = 1'b1; s_req_tlast = 1'b1;
        @(negedge clk);
        chk("t3_next_blocked", s_req_tready, 0);
        s_req_tvalid = 1'b0; s_req_tlast = 1'b0;
        @(posedge clk); #1;
        reply();
        limit_en = 1'b0;

        // Timestamp wrap.
        goto_ts(8'd250);
        beat(1'b1, w);
        goto_ts(8'd4);
        reply();
        chk("t5_wrap_lat", lat_last, 10);

        // Latency floor of 1 and saturating sum.
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        chk("clr_lat_sum", lat_sum, 0);
        chk("clr_lat_min", lat_min, 8'hFF);
        chk("clr_nr_received", nr_received, 0);
        goto_ts(8'd10);
        beat(1'b1, w);
        goto_ts(8'd10);
        reply();
        chk("sat_lat_floor", lat_last, 1);
        goto_ts(8'd20);  beat(1'b1, w);
        goto_ts(8'd220); reply();
        chk("sat_lat_200", lat_last, 200);
        goto_ts(8'd230); beat(1'b1, w);
        goto_ts(8'd74);  reply();
        chk("sat_lat_100", lat_last, 100);
        chk("sat_lat_sum", lat_sum, 8'hFF);
        chk("sat_lat_min", lat_min, 1);
        chk("sat_lat_max", lat_max, 200);
        chk("sat_nr_received", nr_received, 3);

        // Reply end on an empty FIFO with a same-cycle push is an underflow.
        rpl_tvalid = 1'b1; rpl_tready = 1'b1; rpl_tlast = 1'b1;
        s_req_tvalid = 1'b1; s_req_tlast = 1'b1;
        @(posedge clk); #1;
        rpl_tvalid = 1'b0; rpl_tready = 1'b0; rpl_tlast = 1'b0;
        s_req_tvalid = 1'b0; s_req_tlast = 1'b0;
        chk("t4_underflow", underflow, 1);
        chk("t4_lat_valid", lat_valid, 0);
        chk("t4_nr_received", nr_received, 3);
        chk("t4_outstanding", outstanding, 1);
        repeat (2) @(posedge clk);
        #1;
        chk("t4_sticky", underflow, 1);
        reply();

        // FIFO full without limit, then clear, then reset mid-packet.
        for (int i = 0; i < 4; i++) beat(1'b1, w);
        chk("t6_full", outstanding, 4);
        s_req_tvalid = 1'b1; s_req_tlast = 1'b1;
        @(negedge clk);
        chk("t6_fifth_blocked", s_req_tready, 0);
        chk("t6_fifth_tvalid", m_req_tvalid, 0);
        @(posedge clk); #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        s_req_tvalid = 1'b0; s_req_tlast = 1'b0;
        chk("t6_clr_nr_sent", nr_sent, 0);
        chk("t6_clr_underflow", underflow, 0);
        chk("t6_clr_lat_min", lat_min, 8'hFF);
        chk("t6_clr_outstanding", outstanding, 4);
        reply();
        beat(1'b0, w);
        s_req_tvalid = 1'b1; s_req_tlast = 1'b0;
        sys_rst = 1'b1;
        #1;
        chk("t6_rst_outstanding", outstanding, 0);
        chk("t6_rst_nr_sent", nr_sent, 0);
        chk("t6_rst_nr_received", nr_received, 0);
        chk("t6_rst_lat_min", lat_min, 8'hFF);
        chk("t6_rst_lat_valid", lat_valid, 0);
        m_req_tready = 1'b0;
        #1;
        chk("t6_rst_tready_lo", s_req_tready, 0);
        m_req_tready = 1'b1;
        #1;
        chk("t6_rst_tready_hi", s_req_tready, 1);
        @(posedge clk); #1;
        sys_rst = 1'b0;
        limit_en = 1'b1; max_outstanding = 3'd0; s_req_tlast = 1'b1;
        #1;
        chk("t6_idle_after_rst", s_req_tready, 0);
        limit_en = 1'b0;
        #1;
        chk("t6_unblocked", s_req_tready, 1);
        s_req_tvalid = 1'b0; s_req_tlast = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
